cpu_run_ctrl: RTL
=================

# cpu_run_ctrl

Run controller that gates the 24-bit CPU's clock enable so a run can be bounded, paused, single-stepped or stopped at a breakpoint. It generalises the fixed "run 30 cycles then stop" bench flow into a parametrised, synthesizable block. It sits between the top level (or bench) and the CPU's clock-enable and PC/halt status.

## Interface
- `CYCLE_W`, 16: cycle counter and budget width.
- `ADDR_W`, 24: PC / breakpoint address width.
- `Clock`  in  1  sole clock, rising edge.
- `Reset`  in  1  asynchronous, active-high; forces IDLE.
- `Start`  in  1  begin a run from IDLE/DONE, or resume from PAUSE.
- `Stop`  in  1  user pause request.
- `Step`  in  1  execute one cycle while PAUSED.
- `Mode`  in  2  0 FREE, 1 BUDGET, 2 STEP (3 treated as FREE); latched on Start from IDLE/DONE.
- `Budget`  in  CYCLE_W  enabled-cycle limit for BUDGET; latched with Mode.
- `Halt`  in  1  CPU halt status.
- `PC`  in  ADDR_W  CPU program counter.
- `BpEn`  in  1  breakpoint enable.
- `BpAddr`  in  ADDR_W  breakpoint address.
- `CpuEn`  out  1  CPU clock enable (combinational from state and inputs).
- `CycleCount`  out  CYCLE_W  enabled cycles since run start; saturates at all-ones.
- `Busy`  out  1  state is RUN or STEP.
- `Paused`  out  1  state is PAUSE.
- `Done`  out  1  state is DONE.
- `Cause`  out  2  0 NONE, 1 BUDGET, 2 HALT, 3 BREAK.

## Operation
- States: IDLE, RUN, STEP, PAUSE, DONE. Reset: IDLE, CycleCount 0, Cause NONE, latched mode FREE, budget 0, skip flag 0; all status outputs 0, CpuEn 0.
- IDLE/DONE + Start: clear CycleCount and Cause, latch Mode/Budget; go to PAUSE if mode STEP, DONE with Cause BUDGET if mode BUDGET and Budget==0, otherwise RUN.
- bp_hit = BpEn && PC==BpAddr && !skip.
- CpuEn = (state==RUN && !bp_hit && !Halt) || (state==STEP && !Halt).
- RUN transitions, in priority order: Halt -> DONE/HALT; Stop -> PAUSE/NONE; bp_hit -> PAUSE/BREAK (the instruction at BpAddr is not executed); BUDGET mode and CpuEn and CycleCount+1==budget -> DONE/BUDGET; otherwise stay.
- STEP: lasts exactly one cycle, then returns to PAUSE (DONE/HALT if Halt). The breakpoint is ignored in STEP.
- PAUSE: Halt -> DONE/HALT; Start -> RUN with skip=1 for that first RUN cycle (allows executing past the breakpoint instruction), Cause cleared; Step -> STEP. Start in PAUSE with mode STEP acts as Step.
- Simultaneous commands: Stop > Start > Step. Commands not listed for a state are ignored (e.g. Start while RUN, Step while RUN).
- CycleCount increments on every cycle with CpuEn=1. It saturates and never wraps. BUDGET termination still fires on count equality.
- skip clears after one RUN cycle regardless of whether CpuEn was high.

## Timing
- All state, count and Cause updates occur on the rising Clock edge. Reset acts immediately, including mid-run.
- Start in IDLE at edge k: RUN visible after k, CpuEn high the same cycle (unless bp_hit/Halt).
- BUDGET N≥1: exactly N CpuEn cycles, then Done=1 on the cycle after the Nth; CycleCount==N.
- Breakpoint: CpuEn drops combinationally in the cycle PC==BpAddr; PAUSE from the next edge.
- Stop: the cycle Stop is seen is still enabled (if otherwise enabled); PAUSE follows.
- Step: exactly one CpuEn pulse, one cycle after the Step sample.

## Structure
- Package `cpu_run_pkg`: state encoding (3 bits), mode constants FREE/BUDGET/STEP, cause constants NONE/BUDGET/HALT/BREAK.
- One sub-module: `sat_counter` (parametrised width, clear, increment-enable, saturating) for CycleCount. The FSM, breakpoint compare and skip flag stay in `cpu_run_ctrl`.

## Test plan
- Mode BUDGET, Budget=30, Start pulse -> exactly 30 CpuEn cycles, then Done=1, Cause=1, CycleCount=30.
- Mode FREE, BpEn=1, BpAddr=0x000010, PC reaches 0x10 -> CpuEn=0 that cycle, Paused=1, Cause=3; Start -> one enabled cycle with PC=0x10, then run continues.
- Mode STEP, three Step pulses -> exactly three single-cycle CpuEn pulses, CycleCount=3, Paused stays 1 between pulses.
- Mode FREE, Halt=1 after 7 cycles -> Done=1, Cause=2, CycleCount=7; Start and Stop asserted together in RUN -> PAUSE (Stop wins).
- Mode BUDGET with Budget=0 -> Done immediately with Cause=1 and no CpuEn; CYCLE_W=4 with FREE run of 20 cycles -> CycleCount holds at 15.
- Reset asserted mid-RUN between edges -> outputs clear immediately, IDLE, CpuEn=0; the next Start behaves as a fresh run.

Source files
------------

// File: rtl/cpu_run_pkg.sv
// Shared encodings for the CPU run controller: FSM states, run modes and stop causes.
package cpu_run_pkg;

  typedef logic [1:0] mode_t;
  typedef logic [1:0] cause_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_STEP  = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Mode 3 is not decoded anywhere, so it behaves as FREE.
  localparam mode_t MODE_FREE   = 2'd0;
  localparam mode_t MODE_BUDGET = 2'd1;
  localparam mode_t MODE_STEP   = 2'd2;

  localparam cause_t CAUSE_NONE   = 2'd0;
  localparam cause_t CAUSE_BUDGET = 2'd1;
  localparam cause_t CAUSE_HALT   = 2'd2;
  localparam cause_t CAUSE_BREAK  = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + ONE;
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Gates the CPU clock enable so a run can be bounded, paused, single-stepped or
// stopped at a breakpoint.
//
// state | meaning
// IDLE  | after reset, CPU held
// RUN   | CPU enabled each cycle unless breakpoint or halt
// STEP  | one enabled cycle, then back to PAUSE
// PAUSE | held, waiting for Start/Step
// DONE  | run finished; Cause says why
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int CYCLE_W = 16,
  parameter int ADDR_W  = 24
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               step,
  input  logic [1:0]         mode,
  input  logic [CYCLE_W-1:0] budget,
  input  logic               halt,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               bp_en,
  input  logic [ADDR_W-1:0]  bp_addr,
  output logic               cpu_en,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic               busy,
  output logic               paused,
  output logic               done,
  output logic [1:0]         cause
);

  logic [2:0]         state, state_nxt;
  mode_t              mode_q, mode_nxt;
  logic [CYCLE_W-1:0] budget_q, budget_nxt;
  cause_t             cause_q, cause_nxt;
  logic               skip, skip_nxt;
  logic               cnt_clr;
  logic               bp_hit;
  logic               budget_hit;
  logic [CYCLE_W:0]   cnt_inc;

  // skip masks the breakpoint for the first cycle after a resume so the
  // instruction parked at bp_addr can execute.
  assign bp_hit  = bp_en && (pc == bp_addr) && !skip;
  assign cpu_en  = ((state == ST_RUN) && !bp_hit && !halt) ||
                   ((state == ST_STEP) && !halt);
  // Extra bit keeps the compare correct when the count sits at all-ones.
  assign cnt_inc = {1'b0, cycle_count} + {{CYCLE_W{1'b0}}, 1'b1};
  assign budget_hit = (mode_q == MODE_BUDGET) && cpu_en && (cnt_inc == {1'b0, budget_q});

  always_comb begin
    state_nxt  = state;
    mode_nxt   = mode_q;
    budget_nxt = budget_q;
    cause_nxt  = cause_q;
    skip_nxt   = skip;
    cnt_clr    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          cnt_clr    = 1'b1;
          cause_nxt  = CAUSE_NONE;
          mode_nxt   = mode;
          budget_nxt = budget;
          if (mode == MODE_STEP)
            state_nxt = ST_PAUSE;
          else if ((mode == MODE_BUDGET) && (budget == '0)) begin
            state_nxt = ST_DONE;
            cause_nxt = CAUSE_BUDGET;
          end else
            state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        skip_nxt = 1'b0;
        if (halt) begin
          state_nxt = ST_DONE;
          cause_nxt = CAUSE_HALT;
        end else if (stop) begin
          state_nxt = ST_PAUSE;
          cause_nxt = CAUSE_NONE;
        end else if (bp_hit) begin
          state_nxt = ST_PAUSE;
          cause_nxt = CAUSE_BREAK;
        end else if (budget_hit) begin
          state_nxt = ST_DONE;
          cause_nxt = CAUSE_BUDGET;
        end
      end
      ST_STEP: begin
        if (halt) begin
          state_nxt = ST_DONE;
          cause_nxt = CAUSE_HALT;
        end else
          state_nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (halt) begin
          state_nxt = ST_DONE;
          cause_nxt = CAUSE_HALT;
        end else if (start) begin
          if (mode_q == MODE_STEP)
            state_nxt = ST_STEP;
          else begin
            state_nxt = ST_RUN;
            skip_nxt  = 1'b1;
            cause_nxt = CAUSE_NONE;
          end
        end else if (step)
          state_nxt = ST_STEP;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      mode_q   <= MODE_FREE;
      budget_q <= '0;
      cause_q  <= CAUSE_NONE;
      skip     <= 1'b0;
    end else begin
      state    <= state_nxt;
      mode_q   <= mode_nxt;
      budget_q <= budget_nxt;
      cause_q  <= cause_nxt;
      skip     <= skip_nxt;
    end
  end

  sat_counter #(.W(CYCLE_W)) u_cycle_cnt (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clr),
    .inc   (cpu_en),
    .count (cycle_count)
  );

  assign busy   = (state == ST_RUN) || (state == ST_STEP);
  assign paused = (state == ST_PAUSE);
  assign done   = (state == ST_DONE);
  assign cause  = cause_q;

endmodule
